// File: rtl/pool2d_stream.sv
// Streaming non-overlapping KxK max/average pooling over one raster-order channel.
// Per-column-window partial results live in a small buffer; one-deep output register.
module pool2d_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);
  localparam int LOGK  = $clog2(K);
  localparam int ACC_W = WIDTH + 2 * LOGK;
  localparam int NB    = IMG_W / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW    = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic             mode_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_last_reg;

  // Not reset: every entry is loaded by a window's first pixel before it is read.
  logic [ACC_W-1:0] part_mem [NB];

  logic             accept;
  logic             frame_start;
  logic             win_first;
  logic             win_last;
  logic             frame_end;
  logic [IW-1:0]    idx;
  logic [ACC_W-1:0] entry;
  logic [ACC_W-1:0] pix_ext;
  logic [ACC_W-1:0] acc_next;
  logic [WIDTH-1:0] result;

  // Gating with rst keeps in_ready low for the whole time reset is held.
  assign in_ready  = rst & en & (~out_valid_reg | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  assign frame_start = (col_reg == '0) && (row_reg == '0);
  assign win_first   = (col_reg[LOGK-1:0] == '0) && (row_reg[LOGK-1:0] == '0);
  assign win_last    = (col_reg[LOGK-1:0] == '1) && (row_reg[LOGK-1:0] == '1);
  assign frame_end   = (col_reg == CW'(IMG_W - 1)) && (row_reg == RW'(IMG_H - 1));
  assign idx         = IW'(col_reg >> LOGK);
  assign entry       = part_mem[idx];
  assign pix_ext     = ACC_W'(in_data);

  always_comb begin
    acc_next = pix_ext;
    if (!win_first) begin
      if (mode_reg) begin
        acc_next = entry + pix_ext;
      end else if (entry > pix_ext) begin
        acc_next = entry;
      end
    end
  end

  // Average divides by K*K with a plain shift (truncation); max fits in WIDTH bits.
  assign result = mode_reg ? WIDTH'(acc_next >> (2 * LOGK)) : acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (accept) begin
      part_mem[idx] <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      if (accept) begin
        if (col_reg == CW'(IMG_W - 1)) begin
          col_reg <= '0;
          row_reg <= (row_reg == RW'(IMG_H - 1)) ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
        if (frame_start) begin
          mode_reg <= mode;
        end
      end
      // A completing pixel is only accepted when the register is empty or draining.
      if (accept && win_last) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result;
        out_last_reg  <= frame_end;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream (4x4 image, K=2, 8-bit): frame table plus
// scoreboard queue, with hand-written backpressure, mode, enable-gap and reset sequences.
module tb_pool2d_stream;
  localparam int N_PIX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  pool2d_stream #(.WIDTH(8), .IMG_W(4), .IMG_H(4), .K(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            mode;
    logic [15:0][7:0] pix;
    logic [3:0][7:0]  exp;
  } frame_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } res_t;

  frame_t tbl [5];
  res_t   sb_q [$];
  int     checks = 0;
  int     errors = 0;
  bit     stall_arm = 1'b0;
  logic [7:0] held;

  int ref_pix [16] = '{25, 56, 0, 0, 12, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ref_exp [4]  = '{200, 0, 0, 0};
  int avg_pix [16] = '{10, 20, 30, 40, 30, 40, 50, 60, 1, 2, 3, 4, 5, 6, 7, 9};
  int avg_exp [4]  = '{25, 45, 3, 5};
  int max_exp [4]  = '{40, 60, 6, 9};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: pop and compare at every completed output handshake.
  always @(negedge clk) begin
    res_t e;
    if (rst && out_valid && out_ready) begin
      $display("out data=%0d last=%0d", out_data, out_last);
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
    end
  end

  // Holds out_ready low for 5 cycles once the first result of an armed frame shows up.
  initial begin : stall_ctl
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && out_valid) begin
        stall_arm = 1'b0;
        held = out_data;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_out_valid", out_valid, 32'd1);
          check("stall_out_data", out_data, held);
          check("stall_in_ready", in_ready, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    end
  end

  task automatic run_frame(input int f, input int toggle_at, input int gap_at,
                           input int rst_after, input bit stall);
    int  r;
    int  c;
    int  w;
    bit  acc;
    res_t e;
    stall_arm = stall;
    for (int p = 0; p < N_PIX; p++) begin
      if (p == 0) mode = tbl[f].mode;
      if (p == toggle_at) mode = ~mode;
      in_valid = 1'b1;
      in_data  = tbl[f].pix[p];
      if (p == gap_at) begin
        en = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("in_ready_en_low", in_ready, 32'd0);
          @(posedge clk);
          #1;
        end
        en = 1'b1;
      end
      r = p / 4;
      c = p % 4;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        if (in_ready) begin
          acc = 1'b1;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            w = (r / 2) * 2 + c / 2;
            e.data = tbl[f].exp[w];
            e.last = (w == 3);
            sb_q.push_back(e);
          end
        end
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (p + 1 == rst_after) begin
        in_valid = 1'b0;
        check("valid_before_rst", out_valid, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", out_last, 32'd0);
        check("rst_in_ready", in_ready, 32'd0);
        sb_q.delete();
        stall_arm = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_left", sb_q.size(), 32'd0);
    check("idle_out_valid", out_valid, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[0].pix[i] = 8'(ref_pix[i]);
      tbl[1].pix[i] = 8'(avg_pix[i]);
      tbl[2].pix[i] = 8'(avg_pix[i]);
      tbl[3].pix[i] = 8'd255;
      tbl[4].pix[i] = 8'd255;
    end
    for (int i = 0; i < 4; i++) begin
      tbl[0].exp[i] = 8'(ref_exp[i]);
      tbl[1].exp[i] = 8'(avg_exp[i]);
      tbl[2].exp[i] = 8'(max_exp[i]);
      tbl[3].exp[i] = 8'd255;
      tbl[4].exp[i] = 8'd255;
    end
    tbl[0].mode = 1'b0;
    tbl[1].mode = 1'b1;
    tbl[2].mode = 1'b0;
    tbl[3].mode = 1'b0;
    tbl[4].mode = 1'b1;

    #12;
    check("reset_out_valid", out_valid, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_last", out_last, 32'd0);
    check("reset_in_ready", in_ready, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 32'd1);

    for (int f = 0; f < 5; f++) run_frame(f, -1, -1, -1, 1'b0);

    run_frame(1, -1, -1, -1, 1'b1);   // backpressure on first result
    run_frame(2, 3, -1, -1, 1'b0);    // mode toggled mid-frame: stays max
    run_frame(1, -1, -1, -1, 1'b0);   // next frame picks up average
    run_frame(1, -1, 2, -1, 1'b0);    // en low for 3 cycles mid-row
    run_frame(0, -1, -1, 6, 1'b0);    // reset after the sixth pixel
    run_frame(0, -1, -1, -1, 1'b0);   // fresh frame from row 0

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
